approx_seq_mult: RTL and testbench

Iterative unsigned shift-add multiplier with a run-time exact/approximate mode, built as the producer stage for the 2:1 exact/approximate result mux. In approximate mode the multiplication skips the TRUNC least-significant multiplier bits, which cuts latency and error-tolerantly drops low partial products. The block also emits a registered mode flag that drives the downstream mux select, so the mux and the product stay aligned.

---
 rtl/mult_pkg.sv | 14 +
 rtl/approx_mult_ctrl.sv | 72 +++++++
 rtl/approx_seq_mult.sv | 96 +++++++++
 tb/tb_approx_seq_mult.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and default sizing for the
// approximate sequential multiplier.
package mult_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int TRUNC_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/approx_mult_ctrl.sv
// FSM and down-counter sequencing the
// shift-add datapath of approx_seq_mult.
module approx_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TRUNC = TRUNC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic approx_en,
  output logic load,
  output logic step,
  output logic last,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  // state and iteration counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // next-state, counter update and datapath strobes
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          count_d = approx_en ? CW'(WIDTH - TRUNC)
                              : CW'(WIDTH);
          state_d = RUN;
        end
      end
      RUN: begin
        step    = 1'b1;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: rtl/approx_seq_mult.sv
// Iterative shift-add multiplier with run-time
// exact/approximate mode and aligned mux select.
module approx_seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TRUNC = TRUNC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               approx_en,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               approx_flag
);

  localparam int PW = 2 * WIDTH;

  logic load, step, last;

  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic             mode_q, mode_d;
  logic [PW-1:0]    product_q, product_d;
  logic             flag_q, flag_d;
  logic [PW-1:0]    acc_sum;

  approx_mult_ctrl #(
    .WIDTH (WIDTH),
    .TRUNC (TRUNC)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .approx_en (approx_en),
    .load      (load),
    .step      (step),
    .last      (last),
    .busy      (busy),
    .done      (done)
  );

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      mode_q    <= 1'b0;
      product_q <= '0;
      flag_q    <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      mode_q    <= mode_d;
      product_q <= product_d;
      flag_q    <= flag_d;
    end
  end

  // shift-add step; the result and its mode flag
  // are published together as RUN hands over to DONE
  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    mode_d    = mode_q;
    product_d = product_q;
    flag_d    = flag_q;
    acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    if (load) begin
      mcand_d  = approx_en ? (PW'(a) << TRUNC) : PW'(a);
      mplier_d = approx_en ? (b >> TRUNC) : b;
      acc_d    = '0;
      mode_d   = approx_en;
    end else if (step) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (last) begin
        product_d = acc_sum;
        flag_d    = mode_q;
      end
    end
  end

  assign product     = product_q;
  assign approx_flag = flag_q;

endmodule

// File: tb/tb_approx_seq_mult.sv
// Self-checking bench for approx_seq_mult:
// directed table, random ops, and corner sequences.
module tb_approx_seq_mult;

  localparam int W = 8;
  localparam int T = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           approx_en = 1'b0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic           approx_flag;

  int checks = 0;
  int errors = 0;

  approx_seq_mult #(
    .WIDTH (W),
    .TRUNC (T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .approx_en   (approx_en),
    .busy        (busy),
    .done        (done),
    .product     (product),
    .approx_flag (approx_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    bit             m;
    logic [2*W-1:0] p;
    int             lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, exp);
    end
  endtask

  // reference: approximate mode ignores the low
  // T bits of the multiplier entirely
  function automatic logic [2*W-1:0] model(
      input logic [W-1:0] x, input logic [W-1:0] y,
      input bit m);
    int unsigned yy;
    yy = m ? (int'(y) / (1 << T)) * (1 << T) : int'(y);
    return (2*W)'(int'(x) * yy);
  endfunction

  // issue one op, track cycle count, check busy/done
  // exclusivity and that the old product is held
  task automatic run_op(input logic [W-1:0] ai,
                        input logic [W-1:0] bi,
                        input bit mi,
                        input bit poke,
                        input logic [2*W-1:0] held,
                        output logic [2*W-1:0] p,
                        output bit f,
                        output int lat);
    @(negedge clk);
    a = ai;
    b = bi;
    approx_en = mi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    p = '0;
    f = 1'b0;
    for (int c = 1; c <= W + 3; c++) begin
      if (done) begin
        lat = c;
        p = product;
        f = approx_flag;
        chk("busy_at_done", 64'(busy), 64'd0);
        break;
      end
      chk("busy_in_run", 64'(busy), 64'd1);
      chk("hold_prev", 64'(product), 64'(held));
      if (poke && c == 3) begin
        start = 1'b1;
        a = ~ai;
        b = ~bi;
        approx_en = ~mi;
      end else if (poke && c == 4) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (lat < 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  logic [2*W-1:0] prev;
  logic [2*W-1:0] p;
  bit             f;
  int             lat;
  logic [W-1:0]   ra, rb;
  bit             rm;

  initial begin
    vecs[0] = '{a: 13,  b: 11,  m: 0, p: 143,   lat: 9};
    vecs[1] = '{a: 13,  b: 11,  m: 1, p: 104,   lat: 7};
    vecs[2] = '{a: 255, b: 255, m: 0, p: 65025, lat: 9};
    vecs[3] = '{a: 255, b: 255, m: 1, p: 64260, lat: 7};
    vecs[4] = '{a: 200, b: 3,   m: 1, p: 0,     lat: 7};
    vecs[5] = '{a: 0,   b: 177, m: 0, p: 0,     lat: 9};
    vecs[6] = '{a: 1,   b: 4,   m: 1, p: 4,     lat: 7};

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    chk("rst_flag", 64'(approx_flag), 64'd0);
    rst_n = 1'b1;

    // directed table, issued back to back
    prev = '0;
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].m, 1'b0,
             prev, p, f, lat);
      chk("tbl_product", 64'(p), 64'(vecs[i].p));
      chk("tbl_flag", 64'(f), 64'(vecs[i].m));
      chk("tbl_latency", 64'(lat), 64'(vecs[i].lat));
      prev = p;
    end

    // start during RUN is ignored, no second done
    run_op(8'd13, 8'd11, 1'b0, 1'b1, prev, p, f, lat);
    chk("poke_product", 64'(p), 64'd143);
    chk("poke_flag", 64'(f), 64'd0);
    chk("poke_latency", 64'(lat), 64'd9);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("poke_no_done", 64'(done), 64'd0);
      chk("poke_idle", 64'(busy), 64'd0);
    end
    chk("poke_held", 64'(product), 64'd143);
    prev = p;

    // asynchronous reset in cycle 4 of RUN
    @(negedge clk);
    a = 8'd200;
    b = 8'd100;
    approx_en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_product", 64'(product), 64'd0);
    chk("mid_rst_flag", 64'(approx_flag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd7, 8'd6, 1'b0, 1'b0, '0, p, f, lat);
    chk("post_rst_product", 64'(p), 64'd42);
    chk("post_rst_flag", 64'(f), 64'd0);
    prev = p;

    // random ops against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rm = 1'($urandom);
      run_op(ra, rb, rm, 1'b0, prev, p, f, lat);
      chk("rnd_product", 64'(p), 64'(model(ra, rb, rm)));
      chk("rnd_flag", 64'(f), 64'(rm));
      chk("rnd_latency", 64'(lat), 64'(rm ? W - T + 1 : W + 1));
      prev = p;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
